mul_share_ctrl: RTL and testbench

Sequencing controller that shares one multi-cycle `dut_if`-style multiplier between `NUM_REQ` requesters.
- Arbitrates requests round-robin and issues the operands through the multiplier's `valid`/`ready` start handshake.
- Waits for the multiplier's `done` pulse and returns the result with the requester ID over a single valid/ready response channel.
- A watchdog converts a hung multiplier into an error response.
- Sits between the requester-side fabric and the multiplier, which it drives through the `dut_hs_mp` signal set.

---
 rtl/mul_share_ctrl_pkg.sv | 23 ++
 rtl/mul_share_ctrl_if.sv | 48 ++++
 rtl/mul_share_ctrl_rr_arbiter.sv | 35 +++
 rtl/mul_share_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_ctrl_pkg.sv
// Shared types and defaults for the shared-multiplier sequencing controller.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int RESULT_WIDTH_DEF = 16;
    localparam int NUM_REQ_DEF      = 4;
    localparam int TIMEOUT_DEF      = 64;

    // (base + off) mod n, for base < n and off <= n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester, response and multiplier handshake signals of the shared-multiplier controller.
interface mul_share_ctrl_if
    import mul_share_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
    parameter int NUM_REQ      = NUM_REQ_DEF
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;

    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [RESULT_WIDTH-1:0] resp_out;
    logic                    resp_err;

    logic [DATA_WIDTH-1:0]   mul_a;
    logic [DATA_WIDTH-1:0]   mul_b;
    logic                    mul_valid;
    logic                    mul_ready;
    logic                    mul_done;
    logic [RESULT_WIDTH-1:0] mul_out;

    logic                    busy;

    modport master (
        input  req_valid, req_a, req_b, resp_ready, mul_ready, mul_done, mul_out,
        output req_ready, resp_valid, resp_id, resp_out, resp_err,
               mul_a, mul_b, mul_valid, busy
    );

    modport slave (
        output req_valid, req_a, req_b, resp_ready, mul_ready, mul_done, mul_out,
        input  req_ready, resp_valid, resp_id, resp_out, resp_err,
               mul_a, mul_b, mul_valid, busy
    );

    modport dut_hs_mp (
        input  mul_a, mul_b, mul_valid,
        output mul_ready, mul_done, mul_out
    );

endinterface

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, with wrap.
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'(wrap_add(int'(ptr), i, NUM_REQ));
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one multi-cycle multiplier between NUM_REQ requesters, with a watchdog on the multiplier.
//   state | meaning
//   IDLE  | waiting for a request; grant + capture operands
//   ISSUE | mul_valid high until the multiplier accepts
//   WAIT  | waiting for mul_done (or watchdog expiry)
//   RESP  | response held until resp_ready
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input logic              clk,
    input logic              rst_n,
    mul_share_ctrl_if.master bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_id;
    logic                    any_req;
    logic                    timeout;

    logic [DATA_WIDTH-1:0]   op_a [NUM_REQ];
    logic [DATA_WIDTH-1:0]   op_b [NUM_REQ];

    logic [DATA_WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [DATA_WIDTH-1:0]   mul_b_q, mul_b_d;
    logic                    mul_valid_q, mul_valid_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]         resp_id_q, resp_id_d;
    logic [RESULT_WIDTH-1:0] resp_out_q, resp_out_d;
    logic                    resp_err_q, resp_err_d;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign op_a[i] = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign op_b[i] = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (bus.req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_req)
    );

    assign timeout = (timer_q == TMR_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   if (timeout) state_d = RESP;
                     else if (mul_valid_q && bus.mul_ready) state_d = WAIT;
            WAIT:    if (bus.mul_done || timeout) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_valid_d  = mul_valid_q;
        id_d         = id_q;
        rr_ptr_d     = rr_ptr_q;
        timer_d      = timer_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_out_d   = resp_out_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    mul_a_d     = op_a[grant_id];
                    mul_b_d     = op_b[grant_id];
                    id_d        = grant_id;
                    timer_d     = '0;
                    mul_valid_d = 1'b1;
                end
            end
            ISSUE, WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A done pulse in the same cycle as expiry still returns the real product.
                if (state_q == WAIT && bus.mul_done) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_out_d   = bus.mul_out;
                    resp_err_d   = 1'b0;
                end else if (timeout) begin
                    mul_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_out_d   = '0;
                    resp_err_d   = 1'b1;
                end else if (state_q == ISSUE && bus.mul_ready) begin
                    mul_valid_d = 1'b0;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    rr_ptr_d     = ID_W'(wrap_add(int'(id_q), 1, NUM_REQ));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_valid_q  <= 1'b0;
            id_q         <= '0;
            rr_ptr_q     <= '0;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_out_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_valid_q  <= mul_valid_d;
            id_q         <= id_d;
            rr_ptr_q     <= rr_ptr_d;
            timer_q      <= timer_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_out_q   <= resp_out_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) ? grant : '0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.mul_valid  = mul_valid_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_out   = resp_out_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a behavioural multiplier and round-robin reference.
module tb_mul_share_ctrl;

    localparam int DW = 8;
    localparam int RW = 16;
    localparam int NR = 4;
    localparam int TO = 64;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [RW-1:0] out;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_share_ctrl_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .NUM_REQ(NR)) bus ();

    mul_share_ctrl #(
        .DATA_WIDTH   (DW),
        .RESULT_WIDTH (RW),
        .NUM_REQ      (NR),
        .TIMEOUT      (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t          sb_q[$];
    int            grant_log[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            grant_cnt = 0;
    logic [IW-1:0] rr_exp = '0;

    bit            hang = 1'b0;
    bit            spur = 1'b0;
    int            stall = 0;
    int            lat = 3;
    int            cd = 0;
    logic [RW-1:0] prod = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Multiplier model: accepts on mul_valid after 'stall' cycles, pulses done 'lat' cycles later.
    initial begin
        bus.mul_ready = 1'b0;
        bus.mul_done  = 1'b0;
        bus.mul_out   = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (spur) begin
                bus.mul_done = 1'b1;
                bus.mul_out  = 16'h1234;
                spur = 1'b0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.mul_done = 1'b1;
                    bus.mul_out  = prod;
                end
            end
            if (bus.mul_valid) begin
                if (stall > 0) begin
                    bus.mul_ready = 1'b0;
                    stall--;
                end else begin
                    bus.mul_ready = 1'b1;
                    prod = RW'(bus.mul_a) * RW'(bus.mul_b);
                    if (!hang) cd = lat;
                end
            end else begin
                bus.mul_ready = 1'b0;
            end
        end
    end

    // Accept monitor: checks the grant against a round-robin reference and pushes the expected response.
    initial begin : acc_mon
        logic [IW-1:0] g;
        logic [IW-1:0] pi;
        logic [IW-1:0] eg;
        bit            found;
        exp_t          e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.req_ready != '0) begin
                g = '0;
                for (int k = 0; k < NR; k++) if (bus.req_ready[k]) g = IW'(k);
                found = 1'b0;
                eg = '0;
                for (int k = 0; k < NR; k++) begin
                    pi = IW'((int'(rr_exp) + k) % NR);
                    if (!found && bus.req_valid[pi]) begin
                        found = 1'b1;
                        eg = pi;
                    end
                end
                chk("grant_onehot", 32'($countones(bus.req_ready)), 32'd1);
                chk("grant_id", 32'(g), 32'(eg));
                e.id  = g;
                e.err = hang;
                e.out = hang ? '0 : RW'(bus.req_a[int'(g)*DW +: DW]) * RW'(bus.req_b[int'(g)*DW +: DW]);
                sb_q.push_back(e);
                grant_log.push_back(int'(g));
                rr_exp = IW'((int'(g) + 1) % NR);
                grant_cnt++;
            end
        end
    end

    // Response monitor: pops the scoreboard on each response handshake.
    initial begin : resp_mon
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.resp_valid && bus.resp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected_id", 32'(bus.resp_id), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                    chk("resp_out", 32'(bus.resp_out), 32'(e.out));
                    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "global timeout");
    end

    task automatic check_idle_outs(input string tag);
        chk({tag, "_req_ready"},  32'(bus.req_ready), 32'd0);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_id"},    32'(bus.resp_id), 32'd0);
        chk({tag, "_resp_out"},   32'(bus.resp_out), 32'd0);
        chk({tag, "_resp_err"},   32'(bus.resp_err), 32'd0);
        chk({tag, "_mul_a"},      32'(bus.mul_a), 32'd0);
        chk({tag, "_mul_b"},      32'(bus.mul_b), 32'd0);
        chk({tag, "_mul_valid"},  32'(bus.mul_valid), 32'd0);
        chk({tag, "_busy"},       32'(bus.busy), 32'd0);
    endtask

    task automatic wait_grant(input int target, input string tag);
        int n = 0;
        while (grant_cnt < target && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (grant_cnt < target) chk(tag, 32'(grant_cnt), 32'(target));
    endtask

    // Raises req_valid[id]; returns in the accept cycle (after the grant is observed).
    task automatic issue(input logic [IW-1:0] id, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int g0;
        g0 = grant_cnt;
        @(negedge clk);
        bus.req_a[int'(id)*DW +: DW] = a;
        bus.req_b[int'(id)*DW +: DW] = b;
        bus.req_valid[id] = 1'b1;
        #3;
        wait_grant(g0 + 1, "grant_wait");
    endtask

    task automatic wait_resp(input int start, output int n);
        n = start;
        while (!bus.resp_valid && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.resp_valid || sb_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (n >= 1000) chk("idle_wait_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin : main
        int   n;
        int   g0;
        bit   seen;

        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check_idle_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, L=3.
        issue(2'd1, 8'd12, 8'd10);
        @(negedge clk);
        bus.req_valid = '0;
        #3;
        chk("single_mul_valid", 32'(bus.mul_valid), 32'd1);
        chk("single_mul_a", 32'(bus.mul_a), 32'd12);
        chk("single_mul_b", 32'(bus.mul_b), 32'd10);
        chk("single_busy", 32'(bus.busy), 32'd1);
        wait_resp(1, n);
        chk("single_latency", 32'(n), 32'd5);
        chk("single_resp_out", 32'(bus.resp_out), 32'd120);
        wait_idle();

        // Round robin from rr_ptr = 0 with all requesters held valid.
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        rr_exp = '0;
        #1;
        check_idle_outs("reset2");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*DW +: DW] = DW'(i + 1);
            bus.req_b[i*DW +: DW] = DW'(i + 3);
        end
        g0 = grant_cnt;
        @(negedge clk);
        bus.req_valid = '1;
        #3;
        wait_grant(g0 + 5, "rr_grant_wait");
        @(negedge clk);
        bus.req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (grant_log.size() > g0 + k)
                chk("rr_order", 32'(grant_log[g0 + k]), 32'(k % NR));
        end
        wait_idle();

        // Max operands with response backpressure.
        bus.resp_ready = 1'b0;
        issue(2'd0, 8'd255, 8'd255);
        @(negedge clk);
        bus.req_valid = '0;
        #3;
        wait_resp(1, n);
        chk("max_latency", 32'(n), 32'd5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #3;
            chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_resp_id", 32'(bus.resp_id), 32'd0);
            chk("hold_resp_out", 32'(bus.resp_out), 32'hFE01);
            chk("hold_resp_err", 32'(bus.resp_err), 32'd0);
            chk("hold_busy", 32'(bus.busy), 32'd1);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        wait_idle();

        // Multiplier start backpressure; a second requester must not be granted meanwhile.
        stall = 5;
        g0 = grant_cnt;
        issue(2'd2, 8'd7, 8'd9);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        bus.req_a[3*DW +: DW] = 8'd3;
        bus.req_b[3*DW +: DW] = 8'd4;
        bus.req_valid[3] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("stall_mul_valid", 32'(bus.mul_valid), 32'd1);
            chk("stall_mul_a", 32'(bus.mul_a), 32'd7);
            chk("stall_mul_b", 32'(bus.mul_b), 32'd9);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        wait_grant(g0 + 2, "stall_grant3_wait");
        @(negedge clk);
        bus.req_valid = '0;
        wait_idle();

        // Hung multiplier -> error response at T+1+TIMEOUT, then normal service resumes.
        hang = 1'b1;
        issue(2'd1, 8'd5, 8'd6);
        @(negedge clk);
        bus.req_valid = '0;
        #3;
        wait_resp(1, n);
        chk("timeout_latency", 32'(n), 32'(TO + 1));
        chk("timeout_err", 32'(bus.resp_err), 32'd1);
        chk("timeout_out", 32'(bus.resp_out), 32'd0);
        chk("timeout_mul_valid", 32'(bus.mul_valid), 32'd0);
        wait_idle();
        hang = 1'b0;
        issue(2'd2, 8'd11, 8'd13);
        @(negedge clk);
        bus.req_valid = '0;
        #3;
        wait_resp(1, n);
        chk("after_timeout_latency", 32'(n), 32'd5);
        chk("after_timeout_out", 32'(bus.resp_out), 32'd143);
        wait_idle();

        // Reset during WAIT: no response afterwards, late done lands in IDLE.
        lat = 20;
        issue(2'd3, 8'd9, 8'd9);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        #3;
        chk("midwait_busy", 32'(bus.busy), 32'd1);
        chk("midwait_mul_valid", 32'(bus.mul_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        rr_exp = '0;
        #1;
        check_idle_outs("rst_wait");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            #3;
            if (bus.resp_valid || bus.busy) seen = 1'b1;
        end
        chk("no_resp_after_reset", 32'(seen), 32'd0);
        lat = 3;

        // Spurious done while idle.
        @(negedge clk);
        spur = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #3;
            if (bus.resp_valid || bus.busy) seen = 1'b1;
        end
        chk("spurious_done_ignored", 32'(seen), 32'd0);

        issue(2'd0, 8'd20, 8'd30);
        @(negedge clk);
        bus.req_valid = '0;
        #3;
        wait_resp(1, n);
        chk("final_latency", 32'(n), 32'd5);
        chk("final_resp_out", 32'(bus.resp_out), 32'd600);
        wait_idle();
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
